button_event: RTL and testbench

- Sits directly downstream of the button debouncer.
- Takes the clean, stable button level and converts it into single-cycle event pulses for the control logic (e.g. single-step/run control of the CPU).
- Events: press, release, short click, long press, and auto-repeat while held.
- All outputs are registered; one clock domain.

---
 rtl/button_event.sv | 127 ++++++++++++
 tb/tb_button_event.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Turns a debounced button level into registered single-cycle press/release/short/long/repeat events.
// One cycle from sample to output; a level held through reset is ignored until it is seen released.
module button_event #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 16,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, PRESSED, LONG} state_t;

  localparam logic [CNT_W-1:0] LC = LONG_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] RC = REPEAT_CYCLES[CNT_W-1:0];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] w_rep_nxt;
  logic [CNT_W-1:0] w_hold_inc;
  logic [CNT_W-1:0] w_rep_inc;
  logic             w_p;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_repeat_nxt;
  logic             w_held_nxt;

  assign w_p        = i_d ^ ACTIVE_LOW;
  assign w_hold_inc = r_hold_cnt + CNT_W'(1);
  assign w_rep_inc  = r_rep_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_rep_nxt     = r_rep_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_short_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      WAIT_LOW: begin
        if (!w_p) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_p) begin
          w_state_nxt = PRESSED;
          w_hold_nxt  = CNT_W'(1);
          w_rep_nxt   = '0;
          w_press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (w_p) begin
          w_hold_nxt = w_hold_inc;
          if (w_hold_inc == LC) begin
            w_state_nxt = LONG;
            w_long_nxt  = 1'b1;
            w_rep_nxt   = '0;
          end
        end else begin
          w_state_nxt   = IDLE;
          w_hold_nxt    = '0;
          w_release_nxt = 1'b1;
          w_short_nxt   = 1'b1;
        end
      end
      LONG: begin
        // hold count is frozen here; only the bounded repeat counter runs
        if (w_p) begin
          if (w_rep_inc == RC) begin
            w_rep_nxt    = '0;
            w_repeat_nxt = REPEAT_EN;
          end else begin
            w_rep_nxt = w_rep_inc;
          end
        end else begin
          w_state_nxt   = IDLE;
          w_hold_nxt    = '0;
          w_rep_nxt     = '0;
          w_release_nxt = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
    w_held_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WAIT_LOW;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      o_press    <= 1'b0;
      o_release  <= 1'b0;
      o_short    <= 1'b0;
      o_long     <= 1'b0;
      o_repeat   <= 1'b0;
      o_held     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      o_press    <= w_press_nxt;
      o_release  <= w_release_nxt;
      o_short    <= w_short_nxt;
      o_long     <= w_long_nxt;
      o_repeat   <= w_repeat_nxt;
      o_held     <= w_held_nxt;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench: three instances (repeat on, repeat off, active-low) sharing clk/rst.
// Output vectors are packed {press, release, short, long, repeat, held}.
module tb_button_event;

  logic clk;
  logic rst;
  logic i_d;
  logic i_dc;
  wire [5:0] oa;
  wire [5:0] ob;
  wire [5:0] oc;

  int n_checks;
  int n_err;

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] P  = 6'b100001;
  localparam logic [5:0] H  = 6'b000001;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] RS = 6'b011000;
  localparam logic [5:0] L  = 6'b000101;
  localparam logic [5:0] RP = 6'b000011;

  button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .i_d(i_d),
    .o_press(oa[5]), .o_release(oa[4]), .o_short(oa[3]), .o_long(oa[2]), .o_repeat(oa[1]), .o_held(oa[0])
  );

  button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .i_d(i_d),
    .o_press(ob[5]), .o_release(ob[4]), .o_short(ob[3]), .o_long(ob[2]), .o_repeat(ob[1]), .o_held(ob[0])
  );

  button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .i_d(i_dc),
    .o_press(oc[5]), .o_release(oc[4]), .o_short(oc[3]), .o_long(oc[2]), .o_repeat(oc[1]), .o_held(oc[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic d, input logic [5:0] ea, input string tag);
    i_d = d;
    tick();
    chk(tag, oa, ea);
  endtask

  task automatic stepc(input logic d, input logic [5:0] ec, input string tag);
    i_dc = d;
    tick();
    chk(tag, oc, ec);
  endtask

  initial begin
    logic [5:0] ea;
    logic [5:0] eb;
    n_checks = 0;
    n_err    = 0;
    rst  = 1'b1;
    i_d  = 1'b0;
    i_dc = 1'b1;
    tick();
    tick();
    chk("reset_a", oa, Z);
    chk("reset_b", ob, Z);
    chk("reset_c", oc, Z);
    rst = 1'b0;

    // short click
    for (int n = 0; n < 3; n++) step(1'b0, Z, "short_idle");
    step(1'b1, P, "short_press");
    step(1'b1, H, "short_held2");
    step(1'b1, H, "short_held3");
    step(1'b0, RS, "short_release");
    step(1'b0, Z, "short_after");

    // long press with repeat (A) and without (B)
    for (int n = 1; n <= 20; n++) begin
      if (n == 1)                            ea = P;
      else if (n == 8)                       ea = L;
      else if (n > 8 && ((n - 8) % 4) == 0)  ea = RP;
      else                                   ea = H;
      eb = (ea == RP) ? H : ea;
      step(1'b1, ea, $sformatf("long_a_s%0d", n));
      chk($sformatf("long_b_s%0d", n), ob, eb);
    end
    step(1'b0, R, "long_release_a");
    chk("long_release_b", ob, R);
    step(1'b0, Z, "long_after");

    // hold exactly 7: still a short click
    for (int n = 1; n <= 7; n++) step(1'b1, (n == 1) ? P : H, $sformatf("h7_s%0d", n));
    step(1'b0, RS, "h7_release");
    step(1'b0, Z, "h7_after");

    // hold exactly 8: long qualifies on the last sample
    for (int n = 1; n <= 8; n++) step(1'b1, (n == 1) ? P : ((n == 8) ? L : H), $sformatf("h8_s%0d", n));
    step(1'b0, R, "h8_release");
    step(1'b0, Z, "h8_after");

    // held through reset
    rst = 1'b1;
    step(1'b1, Z, "thru_rst1");
    step(1'b1, Z, "thru_rst2");
    rst = 1'b0;
    for (int n = 0; n < 10; n++) step(1'b1, Z, $sformatf("thru_hold%0d", n));
    step(1'b0, Z, "thru_low");
    step(1'b1, P, "thru_press");
    step(1'b0, RS, "thru_release");
    step(1'b0, Z, "thru_after");

    // reset mid-hold aborts silently and returns to WAIT_LOW
    step(1'b1, P, "mid_press");
    for (int n = 2; n <= 4; n++) step(1'b1, H, $sformatf("mid_s%0d", n));
    rst = 1'b1;
    step(1'b1, Z, "mid_rst");
    rst = 1'b0;
    for (int n = 0; n < 3; n++) step(1'b1, Z, $sformatf("mid_waitlow%0d", n));
    step(1'b0, Z, "mid_low");
    step(1'b1, P, "mid_repress");
    step(1'b0, RS, "mid_release");
    step(1'b0, Z, "mid_after");

    // active-low, back-to-back clicks
    stepc(1'b1, Z,  "al_idle");
    stepc(1'b0, P,  "al_press1");
    stepc(1'b0, H,  "al_held1");
    stepc(1'b1, RS, "al_release1");
    stepc(1'b0, P,  "al_press2");
    stepc(1'b1, RS, "al_release2");
    stepc(1'b1, Z,  "al_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
